// File: rtl/load_extend_unit_if.sv
// load_extend_unit_if
// Groups the load-return beat (producer side) and the formatted result
// (consumer side) of load_extend_unit into one bundle.
//   in_valid/in_ready        : input beat handshake
//   D, dataSize, sign_en,
//   addr_off                 : raw memory word and access controls
//   out_valid/out_ready      : output handshake (FIFO head)
//   Q, err                   : formatted result and error flag of the head
// master : environment side (drives beats, consumes results)
// slave  : the load_extend_unit itself
interface load_extend_unit_if #(
    parameter int DW = 32
);
    localparam int OW = $clog2(DW / 8);

    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] D;
    logic [1:0]    dataSize;
    logic          sign_en;
    logic [OW-1:0] addr_off;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] Q;
    logic          err;

    modport master (
        output in_valid, D, dataSize, sign_en, addr_off, out_ready,
        input  in_ready, out_valid, Q, err
    );

    modport slave (
        input  in_valid, D, dataSize, sign_en, addr_off, out_ready,
        output in_ready, out_valid, Q, err
    );
endinterface

// File: rtl/load_extend_unit.sv
// load_extend_unit
// Formats memory-read return data: selects the addressed byte lanes,
// zero/sign-extends by access size and flags misaligned or illegal accesses.
// Results go through a DEPTH-entry FIFO with valid/ready so writeback can
// stall; a saturating counter tracks accepted erroneous beats.
// Ports:
//   CLK      in   clock, rising edge
//   CLR      in   asynchronous active-low reset
//   E        in   enable; 0 blocks accepts and pops
//   cnt_clr  in   synchronous clear of err_cnt (wins over increment)
//   err_cnt  out  saturating count of accepted illegal beats
//   bus      slave modport of load_extend_unit_if (beat in, result out)
module load_extend_unit #(
    parameter int DW    = 32,
    parameter int DEPTH = 2,
    parameter int ECW   = 8
) (
    input  logic           CLK,
    input  logic           CLR,
    input  logic           E,
    input  logic           cnt_clr,
    output logic [ECW-1:0] err_cnt,
    load_extend_unit_if.slave bus
);
    localparam int OW = $clog2(DW / 8);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    // ------------------------------------------------------------------
    // Formatting
    // ------------------------------------------------------------------
    logic [DW-1:0] shifted;
    logic [DW-1:0] ext_mask;
    logic [DW-1:0] fmt;
    logic [6:0]    kept_bits;
    logic [OW-1:0] align_mask;
    logic          top_bit;
    logic          illegal;

    always_comb begin
        shifted    = bus.D >> {bus.addr_off, 3'b000};
        kept_bits  = 7'd8 << bus.dataSize;
        top_bit    = 1'b0;
        align_mask = '0;
        illegal    = 1'b0;
        ext_mask   = '0;
        case (bus.dataSize)
            2'b00: top_bit = shifted[7];
            2'b01: begin
                top_bit    = shifted[15];
                align_mask = OW'(1);
            end
            2'b10: begin
                top_bit    = shifted[31];
                align_mask = OW'(3);
            end
            default: begin
                top_bit    = shifted[DW-1];
                align_mask = OW'(7);
                illegal    = (DW == 32);
            end
        endcase
        // Offset must be a multiple of the access size.
        illegal = illegal | (|(bus.addr_off & align_mask));
        // Mask of bits above the kept field; empty for full-width accesses,
        // which therefore pass through untouched whatever sign_en says.
        for (int unsigned i = 0; i < DW; i++) begin
            ext_mask[i] = (i >= 32'(kept_bits));
        end
        fmt = (shifted & ~ext_mask) | ({DW{bus.sign_en & top_bit}} & ext_mask);
        if (illegal) begin
            fmt = '0;
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------
    logic [DW-1:0] mem_q   [DEPTH];
    logic          mem_err [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          full;
    logic          push;
    logic          pop;

    assign full          = (count == CW'(DEPTH));
    assign bus.out_valid = (count != '0);
    assign bus.in_ready  = E & (~full | bus.out_ready);
    assign push          = bus.in_valid & bus.in_ready;
    assign pop           = bus.out_valid & bus.out_ready & E;
    assign bus.Q         = bus.out_valid ? mem_q[rd_ptr] : '0;
    assign bus.err       = bus.out_valid ? mem_err[rd_ptr] : 1'b0;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // When full with a simultaneous pop, wr_ptr equals rd_ptr: the slot
    // written is the head being consumed at this same edge.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wr_ptr]   <= fmt;
            mem_err[wr_ptr] <= illegal;
        end
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Error counter
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            err_cnt <= '0;
        end else if (cnt_clr) begin
            err_cnt <= '0;
        end else if (push && illegal && (err_cnt != '1)) begin
            err_cnt <= err_cnt + ECW'(1);
        end
    end
endmodule

// File: tb/tb_load_extend_unit.sv
// tb_load_extend_unit
// Two instances: dut0 (DW=32, DEPTH=2, ECW=2) and dut1 (DW=64, DEPTH=4, ECW=8).
// Each has a queue-based reference model checked on every falling edge, plus
// literal expectations checked from the stimulus.
module tb_load_extend_unit;
    logic clk;
    logic rst_n;
    logic E;
    logic cnt_clr;
    logic [1:0] err_cnt0;
    logic [7:0] err_cnt1;

    int n_checks = 0;
    int n_fail   = 0;

    load_extend_unit_if #(.DW(32)) b0 ();
    load_extend_unit_if #(.DW(64)) b1 ();

    load_extend_unit #(.DW(32), .DEPTH(2), .ECW(2)) dut0 (
        .CLK(clk), .CLR(rst_n), .E(E), .cnt_clr(cnt_clr),
        .err_cnt(err_cnt0), .bus(b0)
    );
    load_extend_unit #(.DW(64), .DEPTH(4), .ECW(8)) dut1 (
        .CLK(clk), .CLR(rst_n), .E(E), .cnt_clr(cnt_clr),
        .err_cnt(err_cnt1), .bus(b1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: {err, value}. Arithmetic on a 64-bit view, truncated to dw.
    function automatic logic [64:0] model(input logic [63:0] d, input int dw,
                                          input int size, input bit sgn, input int off);
        int nbytes;
        logic [63:0] v;
        logic [63:0] keep;
        nbytes = 1 << size;
        if ((size == 3 && dw == 32) || (off % nbytes) != 0) return {1'b1, 64'd0};
        v = d >> (8 * off);
        if (8 * nbytes < 64) begin
            keep = (64'd1 << (8 * nbytes)) - 64'd1;
            if (sgn && v[8 * nbytes - 1]) v = v | ~keep;
            else                          v = v & keep;
        end
        if (dw == 32) v = v & 64'h0000_0000_FFFF_FFFF;
        return {1'b0, v};
    endfunction

    // ---------------- scoreboard, dut0 ----------------
    logic [63:0] mq0[$];
    bit          me0[$];
    int          mc0 = 0;

    always @(negedge clk) begin : mon0
        logic [64:0] r;
        bit rdy, push, pop;
        if (!rst_n) begin
            mq0.delete(); me0.delete(); mc0 = 0;
        end
        rdy = E && (mq0.size() < 2 || b0.out_ready);
        chk("in_ready0", 64'(b0.in_ready), 64'(rdy));
        chk("out_valid0", 64'(b0.out_valid), 64'(mq0.size() != 0));
        if (mq0.size() != 0) begin
            chk("q0", 64'(b0.Q), mq0[0]);
            chk("err0", 64'(b0.err), 64'(me0[0]));
        end else begin
            chk("q0_empty", 64'(b0.Q), 64'd0);
            chk("err0_empty", 64'(b0.err), 64'd0);
        end
        chk("err_cnt0", 64'(err_cnt0), 64'(mc0));
        if (rst_n) begin
            pop  = (mq0.size() != 0) && b0.out_ready && E;
            push = b0.in_valid && rdy;
            r = model(64'(b0.D), 32, int'(b0.dataSize), b0.sign_en, int'(b0.addr_off));
            if (pop) begin
                void'(mq0.pop_front());
                void'(me0.pop_front());
            end
            if (push) begin
                mq0.push_back(r[63:0]);
                me0.push_back(r[64]);
            end
            if (cnt_clr) mc0 = 0;
            else if (push && r[64] && mc0 < 3) mc0++;
        end
    end

    // ---------------- scoreboard, dut1 ----------------
    logic [63:0] mq1[$];
    bit          me1[$];
    int          mc1 = 0;

    always @(negedge clk) begin : mon1
        logic [64:0] r;
        bit rdy, push, pop;
        if (!rst_n) begin
            mq1.delete(); me1.delete(); mc1 = 0;
        end
        rdy = E && (mq1.size() < 4 || b1.out_ready);
        chk("in_ready1", 64'(b1.in_ready), 64'(rdy));
        chk("out_valid1", 64'(b1.out_valid), 64'(mq1.size() != 0));
        if (mq1.size() != 0) begin
            chk("q1", b1.Q, mq1[0]);
            chk("err1", 64'(b1.err), 64'(me1[0]));
        end else begin
            chk("q1_empty", b1.Q, 64'd0);
            chk("err1_empty", 64'(b1.err), 64'd0);
        end
        chk("err_cnt1", 64'(err_cnt1), 64'(mc1));
        if (rst_n) begin
            pop  = (mq1.size() != 0) && b1.out_ready && E;
            push = b1.in_valid && rdy;
            r = model(b1.D, 64, int'(b1.dataSize), b1.sign_en, int'(b1.addr_off));
            if (pop) begin
                void'(mq1.pop_front());
                void'(me1.pop_front());
            end
            if (push) begin
                mq1.push_back(r[63:0]);
                me1.push_back(r[64]);
            end
            if (cnt_clr) mc1 = 0;
            else if (push && r[64] && mc1 < 255) mc1++;
        end
    end

    // ---------------- drivers ----------------
    // Present a beat, wait (bounded) until it is accepted; returns at edge+1.
    task automatic beat0(input logic [31:0] d, input logic [1:0] sz, input logic s,
                         input logic [1:0] off);
        bit acc, ok;
        b0.in_valid = 1'b1; b0.D = d; b0.dataSize = sz; b0.sign_en = s; b0.addr_off = off;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            acc = b0.in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                ok = 1;
                break;
            end
        end
        b0.in_valid = 1'b0;
        if (!ok) chk("accept0_timeout", 64'd0, 64'd1);
    endtask

    task automatic beat1(input logic [63:0] d, input logic [1:0] sz, input logic s,
                         input logic [2:0] off);
        bit acc, ok;
        b1.in_valid = 1'b1; b1.D = d; b1.dataSize = sz; b1.sign_en = s; b1.addr_off = off;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            acc = b1.in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                ok = 1;
                break;
            end
        end
        b1.in_valid = 1'b0;
        if (!ok) chk("accept1_timeout", 64'd0, 64'd1);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [64:0] m;
        rst_n = 1'b0; E = 1'b1; cnt_clr = 1'b0;
        b0.in_valid = 0; b0.D = '0; b0.dataSize = '0; b0.sign_en = 0; b0.addr_off = '0; b0.out_ready = 1;
        b1.in_valid = 0; b1.D = '0; b1.dataSize = '0; b1.sign_en = 0; b1.addr_off = '0; b1.out_ready = 1;
        #1;
        chk("rst_out_valid", 64'(b0.out_valid), 64'd0);
        chk("rst_q", 64'(b0.Q), 64'd0);
        chk("rst_err_cnt", 64'(err_cnt0), 64'd0);
        chk("rst_in_ready", 64'(b0.in_ready), 64'd1);

        // Pin the reference model against hand-computed values.
        m = model(64'h1234_80F0, 32, 0, 1, 1);
        chk("model_byte", m, {1'b0, 64'hFFFF_FF80});
        m = model(64'h8000_0000_1234_5678, 64, 2, 1, 4);
        chk("model_word64", m, {1'b0, 64'hFFFF_FFFF_8000_0000});
        m = model(64'h8001_7FFF, 32, 1, 1, 1);
        chk("model_misalign", m, {1'b1, 64'd0});

        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // Byte / half extraction on DW=32.
        beat0(32'h1234_80F0, 2'b00, 1, 2'd0);
        chk("byte_s_off0", 64'(b0.Q), 64'hFFFF_FFF0);
        chk("byte_s_off0_err", 64'(b0.err), 64'd0);
        beat0(32'h1234_80F0, 2'b00, 1, 2'd1);
        chk("byte_s_off1", 64'(b0.Q), 64'hFFFF_FF80);
        beat0(32'h1234_80F0, 2'b00, 0, 2'd1);
        chk("byte_u_off1", 64'(b0.Q), 64'h0000_0080);
        beat0(32'h8001_7FFF, 2'b01, 1, 2'd2);
        chk("half_s_off2", 64'(b0.Q), 64'hFFFF_8001);
        beat0(32'h8001_7FFF, 2'b01, 1, 2'd1);
        chk("half_misalign_q", 64'(b0.Q), 64'd0);
        chk("half_misalign_err", 64'(b0.err), 64'd1);
        chk("half_misalign_cnt", 64'(err_cnt0), 64'd1);
        beat0(32'h1122_3344, 2'b11, 0, 2'd0);
        chk("dbl_on_32_err", 64'(b0.err), 64'd1);
        beat0(32'hDEAD_BEEF, 2'b10, 1, 2'd0);
        chk("word_pass32", 64'(b0.Q), 64'hDEAD_BEEF);
        tick();
        chk("drained0", 64'(b0.out_valid), 64'd0);

        // DW=64 accesses.
        beat1(64'h8000_0000_1234_5678, 2'b10, 1, 3'd4);
        chk("word64_s", b1.Q, 64'hFFFF_FFFF_8000_0000);
        beat1(64'h8000_0000_1234_5678, 2'b11, 1, 3'd0);
        chk("dbl64_pass", b1.Q, 64'h8000_0000_1234_5678);
        beat1(64'h8000_0000_1234_5678, 2'b01, 1, 3'd6);
        chk("half64_s", b1.Q, 64'hFFFF_FFFF_FFFF_8000);
        beat1(64'h8000_0000_1234_5678, 2'b00, 1, 3'd3);
        chk("byte64_off3", b1.Q, 64'h0000_0000_0000_0012);
        beat1(64'h8000_0000_1234_5678, 2'b10, 0, 3'd2);
        chk("word64_misalign", 64'(b1.err), 64'd1);
        tick();

        // Backpressure: DEPTH=2 fills, then push+pop in one cycle.
        b0.out_ready = 0;
        beat0(32'h0000_00AA, 2'b00, 0, 2'd0);
        beat0(32'h0000_BB00, 2'b01, 0, 2'd0);
        b0.in_valid = 1; b0.D = 32'h0000_00CC; b0.dataSize = 2'b00; b0.sign_en = 0; b0.addr_off = 2'd0;
        tick();
        chk("full_in_ready", 64'(b0.in_ready), 64'd0);
        chk("full_head", 64'(b0.Q), 64'h0000_00AA);
        tick();
        chk("full_hold", 64'(b0.in_ready), 64'd0);
        b0.out_ready = 1;
        #1;
        chk("full_ready_pass", 64'(b0.in_ready), 64'd1);
        tick();
        b0.in_valid = 0;
        chk("pushpop_head", 64'(b0.Q), 64'h0000_BB00);
        chk("pushpop_valid", 64'(b0.out_valid), 64'd1);
        tick();
        chk("order_third", 64'(b0.Q), 64'h0000_00CC);
        tick();
        chk("bp_drained", 64'(b0.out_valid), 64'd0);

        // Saturation at ECW=2 and clear priority.
        cnt_clr = 1;
        tick();
        cnt_clr = 0;
        chk("cnt_cleared", 64'(err_cnt0), 64'd0);
        for (int i = 0; i < 5; i++) beat0(32'h0, 2'b01, 0, 2'd1);
        chk("cnt_saturate", 64'(err_cnt0), 64'd3);
        cnt_clr = 1;
        beat0(32'h0, 2'b01, 0, 2'd3);
        cnt_clr = 0;
        chk("cnt_clr_priority", 64'(err_cnt0), 64'd0);
        tick();

        // Enable low freezes the FIFO.
        b0.out_ready = 0;
        beat0(32'h0000_005A, 2'b00, 0, 2'd0);
        E = 0;
        b0.out_ready = 1;
        tick();
        tick();
        chk("e0_hold_valid", 64'(b0.out_valid), 64'd1);
        chk("e0_hold_q", 64'(b0.Q), 64'h0000_005A);
        chk("e0_in_ready", 64'(b0.in_ready), 64'd0);
        E = 1;
        tick();
        chk("e1_popped", 64'(b0.out_valid), 64'd0);

        // Reset with two entries buffered.
        b0.out_ready = 0;
        beat0(32'h0, 2'b01, 0, 2'd1);
        beat0(32'h0000_0077, 2'b00, 0, 2'd0);
        chk("pre_rst_cnt", 64'(err_cnt0), 64'd1);
        #2 rst_n = 0;
        #1;
        chk("arst_out_valid", 64'(b0.out_valid), 64'd0);
        chk("arst_q", 64'(b0.Q), 64'd0);
        chk("arst_err_cnt", 64'(err_cnt0), 64'd0);
        chk("arst_in_ready", 64'(b0.in_ready), 64'd1);
        tick();
        rst_n = 1;
        b0.out_ready = 1;
        beat0(32'h0000_0099, 2'b00, 0, 2'd0);
        chk("post_rst_head", 64'(b0.Q), 64'h0000_0099);
        chk("post_rst_valid", 64'(b0.out_valid), 64'd1);
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/load_extend_unit.md
# load_extend_unit

Parametrised load-data formatter for the datapath's memory-read return path, replacing the fixed 32-bit sign extender. It selects the addressed byte lanes, zero- or sign-extends by access size, and flags misaligned or illegal accesses. Results are buffered in a small output FIFO with a valid/ready handshake so the writeback stage can stall. A saturating error counter supports debug and exception logic.

## Interface
- DW, 32: data width; legal values 32 or 64.
- DEPTH, 2: output FIFO entries; legal values 2 to 8.
- ECW, 8: error counter width.
- CLK  in  1  clock; all state updates on the rising edge.
- CLR  in  1  asynchronous, active-low reset.
- E  in  1  enable; when 0, no input is accepted and the FIFO does not pop.
- in_valid  in  1  input beat valid.
- in_ready  out  1  unit can accept a beat.
- D  in  DW  raw memory word.
- dataSize  in  2  00 byte, 01 half, 10 word, 11 double.
- sign_en  in  1  1 sign-extend, 0 zero-extend.
- addr_off  in  log2(DW/8)  byte offset of the access within D.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer takes the head.
- Q  out  DW  formatted result at the FIFO head.
- err  out  1  error flag of the head entry.
- cnt_clr  in  1  synchronous clear of err_cnt.
- err_cnt  out  ECW  saturating count of accepted erroneous beats.

## Operation
- Accept occurs when in_valid & in_ready. Pop occurs when out_valid & out_ready & E.
- in_ready = E & (FIFO not full | out_ready). This allows a push and a pop in the same cycle when the FIFO is full.
- Size in bytes: S = 1, 2, 4 or 8 for dataSize 00, 01, 10 or 11.
- Illegal access:
  - dataSize = 11 when DW = 32.
  - addr_off not a multiple of S (misaligned).
- Legal access:
  - Shift D right by 8*addr_off.
  - Keep the low 8*S bits.
  - Fill the upper bits with the top kept bit if sign_en = 1, else with 0.
  - A full-width access (S*8 = DW) passes through unchanged regardless of sign_en.
- Illegal access: the entry stores Q = 0 and err = 1. Legal access: err = 0.
- FIFO behaviour:
  - Circular FIFO of DEPTH entries, each holding {Q, err}.
  - Read and write pointers wrap modulo DEPTH.
  - An occupancy counter runs 0..DEPTH.
  - Q and err are driven from the head entry.
  - When the FIFO is empty, Q = 0 and err = 0.
- err_cnt:
  - Increments by 1 on each accepted illegal beat.
  - Saturates at 2^ECW - 1.
  - cnt_clr has priority over an increment in the same cycle.
- E = 0 freezes the FIFO pointers and occupancy. err_cnt still honours cnt_clr.

## Timing
- Latency is 1 cycle: a beat accepted at edge k is visible on Q, err and out_valid immediately after edge k, if the FIFO was empty.
- Throughput is 1 beat per cycle, sustained while out_ready = 1.
- Values after CLR falls (asynchronous, immediate):
  - out_valid = 0, Q = 0, err = 0, err_cnt = 0.
  - Pointers and occupancy = 0.
  - in_ready = E.
- Reset mid-operation discards every buffered entry. No entry survives reset.
- in_ready and Q may depend combinationally on out_ready and E. out_valid is registered state (occupancy ≠ 0).
- Simultaneous events:
  - Push and pop when empty: not possible, since out_valid = 0.
  - Push and pop when full: occupancy is unchanged and both pointers advance.
  - Push and pop otherwise: occupancy is unchanged.
- Holding in_valid while in_ready = 0 has no effect. The producer must hold D and its controls stable.

## Test plan
- DW=32. D=0x1234_80F0, dataSize=00, sign_en=1, addr_off=0 -> Q=0xFFFF_FFF0, err=0. With addr_off=1 -> Q=0xFFFF_FF80. With sign_en=0, addr_off=1 -> Q=0x0000_0080.
- DW=32. D=0x8001_7FFF, dataSize=01, addr_off=2, sign_en=1 -> Q=0xFFFF_8001. With addr_off=1 -> Q=0, err=1, err_cnt increments to 1.
- DW=64. D=0x8000_0000_1234_5678, dataSize=10, addr_off=4, sign_en=1 -> Q=0xFFFF_FFFF_8000_0000. dataSize=11, addr_off=0 -> Q equals D. DW=32 with dataSize=11 -> err=1.
- Backpressure with DEPTH=2: push 3 beats with out_ready=0 -> in_ready drops to 0 after 2 accepts. Raise out_ready while in_valid stays 1 -> push and pop occur in the same cycle, output order is preserved, and occupancy stays at 2.
- ECW=2: 5 illegal beats -> err_cnt saturates at 3. Assert cnt_clr in the same cycle as an illegal beat -> err_cnt = 0.
- Assert CLR with 2 entries buffered -> out_valid=0, Q=0 and err_cnt=0 immediately. After release, the first new beat appears at the head 1 cycle after acceptance.
